// File: rtl/rpn_stack_sequencer.sv
// RPN token sequencer: sole master of a push-down stack.
// Operands push, operators pop two and push, END pops the result.
module rpn_stack_sequencer #(
  parameter int DATAWIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 tok_valid_i,
  output logic                 tok_ready_o,
  input  logic                 tok_op_i,
  input  logic [DATAWIDTH-1:0] tok_data_i,
  output logic                 stk_pushpop_o,
  output logic                 stk_en_o,
  output logic [DATAWIDTH-1:0] stk_data_o,
  input  logic [DATAWIDTH-1:0] stk_data_i,
  input  logic                 stk_empty_i,
  input  logic                 stk_full_i,
  output logic                 res_valid_o,
  output logic [DATAWIDTH-1:0] res_data_o,
  output logic                 err_o,
  output logic [1:0]           err_code_o,
  input  logic                 err_clr_i
);

  typedef enum logic [2:0] {
    IDLE, PUSH, POPB, POPA, EXEC, POPR, RESULT, ERR
  } state_e;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_END = 3'd7;

  localparam logic [1:0] E_UNDER = 2'b01;
  localparam logic [1:0] E_OVER  = 2'b10;
  localparam logic [1:0] E_ILL   = 2'b11;

  state_e               state_q, state_d;
  logic [DATAWIDTH-1:0] data_q, data_d;
  logic [DATAWIDTH-1:0] a_q, a_d;
  logic [DATAWIDTH-1:0] b_q, b_d;
  logic [DATAWIDTH-1:0] res_q, res_d;
  logic [2:0]           op_q, op_d;
  logic [1:0]           code_q, code_d;
  logic [DATAWIDTH-1:0] alu;
  logic                 is_arith;
  logic                 is_end;

  assign is_arith = tok_data_i[2:0] <= OP_XOR;
  assign is_end   = tok_data_i[2:0] == OP_END;

  always_comb begin
    alu = '0;
    unique case (op_q)
      OP_ADD:  alu = a_q + b_q;
      OP_SUB:  alu = a_q - b_q;
      OP_AND:  alu = a_q & b_q;
      OP_OR:   alu = a_q | b_q;
      default: alu = a_q ^ b_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    op_d     = op_q;
    code_d   = code_q;
    stk_en_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tok_valid_i) begin
          if (!tok_op_i) begin
            if (stk_full_i) begin
              state_d = ERR;
              code_d  = E_OVER;
            end else begin
              data_d  = tok_data_i;
              state_d = PUSH;
            end
          end else begin
            unique case (1'b1)
              is_arith: begin
                op_d    = tok_data_i[2:0];
                state_d = POPB;
              end
              is_end:  state_d = POPR;
              default: begin
                state_d = ERR;
                code_d  = E_ILL;
              end
            endcase
          end
        end
      end
      PUSH: begin
        stk_en_o = 1'b1;
        state_d  = IDLE;
      end
      POPB: begin
        if (stk_empty_i) begin
          state_d = ERR;
          code_d  = E_UNDER;
        end else begin
          stk_en_o = 1'b1;
          b_d      = stk_data_i;
          state_d  = POPA;
        end
      end
      POPA: begin
        if (stk_empty_i) begin
          state_d = ERR;
          code_d  = E_UNDER;
        end else begin
          stk_en_o = 1'b1;
          a_d      = stk_data_i;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        data_d  = alu;
        state_d = PUSH;
      end
      POPR: begin
        if (stk_empty_i) begin
          state_d = ERR;
          code_d  = E_UNDER;
        end else begin
          stk_en_o = 1'b1;
          res_d    = stk_data_i;
          state_d  = RESULT;
        end
      end
      RESULT: state_d = IDLE;
      ERR: begin
        if (err_clr_i) begin
          state_d = IDLE;
          code_d  = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= '0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      op_q    <= op_d;
      code_q  <= code_d;
    end
  end

  assign tok_ready_o   = state_q == IDLE;
  assign stk_pushpop_o = state_q != PUSH;
  assign stk_data_o    = data_q;
  assign res_valid_o   = state_q == RESULT;
  assign res_data_o    = res_q;
  assign err_o         = state_q == ERR;
  assign err_code_o    = code_q;

endmodule

// File: tb/tb_rpn_stack_sequencer.sv
// Bench for rpn_stack_sequencer: behavioural stack, queue-based
// RPN reference model, directed and random token streams.
module tb_rpn_stack_sequencer;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          tok_valid_i;
  logic          tok_ready_o;
  logic          tok_op_i;
  logic [DW-1:0] tok_data_i;
  logic          stk_pushpop_o;
  logic          stk_en_o;
  logic [DW-1:0] stk_data_o;
  logic [DW-1:0] stk_data_i;
  logic          stk_empty_i;
  logic          stk_full_i;
  logic          res_valid_o;
  logic [DW-1:0] res_data_o;
  logic          err_o;
  logic [1:0]    err_code_o;
  logic          err_clr_i;

  rpn_stack_sequencer #(.DATAWIDTH(DW)) dut (
    .Clk(Clk), .Rst(Rst),
    .tok_valid_i(tok_valid_i), .tok_ready_o(tok_ready_o),
    .tok_op_i(tok_op_i), .tok_data_i(tok_data_i),
    .stk_pushpop_o(stk_pushpop_o), .stk_en_o(stk_en_o),
    .stk_data_o(stk_data_o), .stk_data_i(stk_data_i),
    .stk_empty_i(stk_empty_i), .stk_full_i(stk_full_i),
    .res_valid_o(res_valid_o), .res_data_o(res_data_o),
    .err_o(err_o), .err_code_o(err_code_o),
    .err_clr_i(err_clr_i)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural push-down stack
  logic [DW-1:0] mem [DEPTH];
  logic [2:0]    cnt;
  int push_cnt = 0;
  int pop_cnt  = 0;
  int res_cnt  = 0;
  int viol     = 0;

  assign stk_empty_i = cnt == 0;
  assign stk_full_i  = cnt == 3'(DEPTH);
  assign stk_data_i  = (cnt != 0) ? mem[cnt[1:0] - 2'd1] : '0;

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cnt <= '0;
    end else begin
      if (stk_en_o) begin
        if (!stk_pushpop_o) begin
          push_cnt++;
          if (cnt == 3'(DEPTH)) viol++;
          else begin
            mem[cnt[1:0]] <= stk_data_o;
            cnt <= cnt + 3'd1;
          end
        end else begin
          pop_cnt++;
          if (cnt == 0) viol++;
          else cnt <= cnt - 3'd1;
        end
      end
      if (res_valid_o) res_cnt++;
    end
  end

  always @(negedge Clk) begin
    if (tok_ready_o && (stk_en_o || res_valid_o || err_o)) viol++;
    if (!stk_en_o && !stk_pushpop_o) viol++;
  end

  // Reference model state
  logic [DW-1:0] q[$];
  int            exp_push = 0;
  int            exp_pop  = 0;
  int            exp_res  = 0;
  logic [DW-1:0] exp_rd   = '0;

  function automatic logic [DW-1:0] rpn_f(input logic [2:0] op,
      input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      3'd0:    return DW'(int'(a) + int'(b));
      3'd1:    return DW'(int'(a) - int'(b));
      3'd2:    return a & b;
      3'd3:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic model(input bit op, input logic [DW-1:0] d,
                       output logic [1:0] code, output bit en1);
    logic [DW-1:0] a, b;
    code = 2'b00;
    en1  = 1'b0;
    if (!op) begin
      if (q.size() == DEPTH) code = 2'b10;
      else begin
        q.push_back(d);
        exp_push++;
        en1 = 1'b1;
      end
    end else if (d[2:0] <= 3'd4) begin
      en1 = q.size() > 0;
      if (q.size() == 0) code = 2'b01;
      else if (q.size() == 1) begin
        void'(q.pop_back());
        exp_pop++;
        code = 2'b01;
      end else begin
        b = q.pop_back();
        a = q.pop_back();
        exp_pop += 2;
        q.push_back(rpn_f(d[2:0], a, b));
        exp_push++;
      end
    end else if (d[2:0] == 3'd7) begin
      en1 = q.size() > 0;
      if (q.size() == 0) code = 2'b01;
      else begin
        exp_rd = q.pop_back();
        exp_pop++;
        exp_res++;
      end
    end else begin
      code = 2'b11;
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send_tok(input bit op, input logic [DW-1:0] d);
    int n = 0;
    tok_op_i    = op;
    tok_data_i  = d;
    tok_valid_i = 1'b1;
    while (!tok_ready_o && n < 20) begin
      @(negedge Clk);
      n++;
    end
    chk("tok_ready", tok_ready_o, 1);
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(tok_ready_o || err_o) && n < 20) begin
      @(negedge Clk);
      n++;
    end
    chk("done", tok_ready_o | err_o, 1);
  endtask

  task automatic check_state(input logic [1:0] code);
    chk("err", err_o, code != 2'b00);
    chk("code", err_code_o, code);
    chk("depth", cnt, q.size());
    if (q.size() > 0) chk("top", stk_data_i, q[$]);
    chk("res_data", res_data_o, exp_rd);
    chk("npush", push_cnt, exp_push);
    chk("npop", pop_cnt, exp_pop);
    chk("nres", res_cnt, exp_res);
  endtask

  task automatic clear_err();
    err_clr_i = 1'b1;
    @(negedge Clk);
    err_clr_i = 1'b0;
    chk("clr_ready", tok_ready_o, 1);
    chk("clr_err", {err_o, err_code_o}, 0);
  endtask

  task automatic run_tok(input bit op, input logic [DW-1:0] d);
    logic [1:0] code;
    bit         en1;
    model(op, d, code, en1);
    send_tok(op, d);
    tok_valid_i = 1'b0;
    chk("en_t1", stk_en_o, en1);
    if (!op && en1) chk("push_t1", {stk_pushpop_o, stk_data_o}, {1'b0, d});
    wait_done();
    check_state(code);
    if (code != 2'b00) begin
      chk("no_ready_err", tok_ready_o, 0);
      repeat (2) @(negedge Clk);
      chk("err_sticky", {err_o, err_code_o}, {1'b1, code});
      clear_err();
    end
  endtask

  task automatic run_seq(input logic [DW:0] seq[$]);
    foreach (seq[i]) run_tok(seq[i][DW], seq[i][DW-1:0]);
  endtask

  localparam logic [DW:0] ADD = 9'h100;
  localparam logic [DW:0] SUB = 9'h101;
  localparam logic [DW:0] OR_ = 9'h103;
  localparam logic [DW:0] XOR = 9'h104;
  localparam logic [DW:0] ILL = 9'h105;
  localparam logic [DW:0] END = 9'h107;

  initial begin
    logic [1:0] code;
    bit         en1;
    logic [DW:0] bb[$];
    Rst         = 1'b0;
    tok_valid_i = 1'b0;
    tok_op_i    = 1'b0;
    tok_data_i  = '0;
    err_clr_i   = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_outs",
        {tok_ready_o, stk_en_o, stk_pushpop_o, stk_data_o,
         res_valid_o, res_data_o, err_o, err_code_o},
        {1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 2'b00});
    Rst = 1'b1;
    @(negedge Clk);

    run_seq('{9'h005, 9'h003, SUB, END});
    chk("sub_res", res_data_o, 8'h02);
    chk("sub_empty", stk_empty_i, 1);
    run_seq('{9'h0FF, 9'h002, ADD, END});
    chk("add_wrap", res_data_o, 8'h01);
    run_seq('{9'h000, 9'h001, SUB, END});
    chk("sub_wrap", res_data_o, 8'hFF);

    run_tok(1'b1, 8'h00);
    run_seq('{9'h011, 9'h022, 9'h033, 9'h044, 9'h055});
    chk("ovf_res_kept", res_data_o, 8'hFF);
    run_seq('{END, END, END, END});
    run_seq('{ILL, 9'h106});

    // Reset during POPA of an ADD
    run_seq('{9'h007, 9'h008});
    model(1'b1, 8'h00, code, en1);
    send_tok(1'b1, 8'h00);
    tok_valid_i = 1'b0;
    @(negedge Clk);
    #2 Rst = 1'b0;
    #1;
    chk("rst_mid",
        {tok_ready_o, stk_en_o, stk_pushpop_o, stk_data_o,
         res_valid_o, res_data_o, err_o, err_code_o},
        {1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 2'b00});
    q.delete();
    exp_push--;
    exp_pop--;
    exp_rd = '0;
    @(negedge Clk);
    #2 Rst = 1'b1;
    repeat (5) @(negedge Clk);
    check_state(2'b00);

    // Back-to-back with valid held high
    bb = '{9'h001, 9'h002, 9'h003, XOR, OR_, END};
    foreach (bb[i]) begin
      model(bb[i][DW], bb[i][DW-1:0], code, en1);
      send_tok(bb[i][DW], bb[i][DW-1:0]);
    end
    tok_valid_i = 1'b0;
    wait_done();
    check_state(2'b00);
    chk("b2b_res", res_data_o, 8'h01);

    // Random token stream
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 50) run_tok(1'b0, 8'($urandom_range(0, 255)));
      else if (r < 85) run_tok(1'b1, 8'($urandom_range(0, 4)));
      else if (r < 95) run_tok(1'b1, 8'h07);
      else run_tok(1'b1, 8'($urandom_range(5, 6)));
    end

    chk("protocol", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
